// File: rtl/johnson_seq_monitor.sv
// Johnson counter sequence monitor: decodes each sampled N-bit Johnson code to a
// phase index, checks code legality and +1 stepping, and tracks lock state and errors.
// Optional macro JSM_STICKY_ERR_EN adds a sticky error flag output (err_sticky).
module johnson_seq_monitor #(
  parameter int unsigned N        = 4,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [N-1:0]               q_in,
  input  logic                       clr_err,
  output logic [$clog2(2*N)-1:0]     phase,
  output logic                       phase_valid,
  output logic                       locked,
  output logic                       err_pulse,
  output logic [ERR_W-1:0]           err_count
`ifdef JSM_STICKY_ERR_EN
  ,
  output logic                       err_sticky
`endif
);

  localparam int unsigned PW = $clog2(2 * N);
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    StUnlocked,
    StAcquire,
    StLocked
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   good_q, good_d;
  logic [PW-1:0]   phase_q;
  logic            phase_valid_q;
  logic            err_pulse_q;
  logic [ERR_W-1:0] err_count_q;

  logic [N-1:0]    norm;
  logic [PW-1:0]   ones;
  logic [PW-1:0]   dec_phase;
  logic            legal;
  logic [PW-1:0]   expect_phase;
  logic            step_good;
  logic            err;

  // Decode: fold MSB=1 codes onto the MSB=0 form, then the code is legal when the
  // folded value is a run of ones starting at the LSB.
  always_comb begin
    norm = q_in[N-1] ? ~q_in : q_in;
    legal = ((norm & (norm + N'(1))) == '0);
    ones = '0;
    for (int i = 0; i < N; i++) begin
      ones = ones + PW'(q_in[i]);
    end
    // MSB=1: phase = N + zeros = 2N - ones
    dec_phase = q_in[N-1] ? (PW'(2 * N) - ones) : ones;
  end

  // The phase register always holds the last legal sample, so it doubles as the
  // reference for the +1 step check.
  always_comb begin
    expect_phase = (phase_q == PW'(2 * N - 1)) ? '0 : phase_q + PW'(1);
    step_good    = (dec_phase == expect_phase);
  end

  // Lock FSM next-state and error detection, evaluated only on valid samples.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err     = 1'b0;
    if (in_valid) begin
      if (!legal) begin
        state_d = StUnlocked;
        good_d  = '0;
        err     = 1'b1;
      end else begin
        unique case (state_q)
          StUnlocked: begin
            state_d = StAcquire;
            good_d  = '0;
          end
          StAcquire: begin
            if (step_good) begin
              good_d = good_q + GW'(1);
              if (good_q + GW'(1) == GW'(LOCK_CNT)) begin
                state_d = StLocked;
              end
            end else begin
              good_d = '0;
            end
          end
          StLocked: begin
            if (!step_good) begin
              state_d = StAcquire;
              good_d  = '0;
              err     = 1'b1;
            end
          end
          default: begin
            state_d = StUnlocked;
            good_d  = '0;
          end
        endcase
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StUnlocked;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Registered outputs: phase, strobes and the saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= '0;
      phase_valid_q <= 1'b0;
      err_pulse_q   <= 1'b0;
      err_count_q   <= '0;
    end else begin
      phase_valid_q <= in_valid && legal;
      err_pulse_q   <= err;
      if (in_valid && legal) begin
        phase_q <= dec_phase;
      end
      // Clear wins over a coincident error.
      if (clr_err) begin
        err_count_q <= '0;
      end else if (err && (err_count_q != '1)) begin
        err_count_q <= err_count_q + ERR_W'(1);
      end
    end
  end

`ifdef JSM_STICKY_ERR_EN
  logic err_sticky_q;

  // Sticky flag: set by any error, cleared only by clr_err (priority) or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky_q <= 1'b0;
    end else if (clr_err) begin
      err_sticky_q <= 1'b0;
    end else if (err) begin
      err_sticky_q <= 1'b1;
    end
  end

  assign err_sticky = err_sticky_q;
`endif

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign locked      = (state_q == StLocked);
  assign err_pulse   = err_pulse_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/johnson_seq_monitor.md
Name: johnson_seq_monitor

Overview:
- Sits directly downstream of the 4-bit Johnson counter and consumes its q output.
- Samples the counter state and decodes it to a binary phase index.
- Checks each code for legality and each sample-to-sample step for the +1 sequence.
- Runs a lock FSM and keeps a saturating error count for status and debug logic.

Parameters:
- N, 4: Johnson counter width (>=2); 2N legal codes.
- LOCK_CNT, 4: consecutive good transitions required to reach LOCKED (>=1).
- ERR_W, 8: err_count width.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  q_in is sampled this cycle.
- q_in  input  N  Johnson counter state.
- clr_err  input  1  clears err_count (synchronous).
- phase  output  $clog2(2N)  decoded phase of last legal sample.
- phase_valid  output  1  one-cycle strobe: phase updated from a legal sample.
- locked  output  1  FSM in LOCKED.
- err_pulse  output  1  one-cycle strobe per detected error.
- err_count  output  ERR_W  saturating error count.

Behaviour:
- Reset (reset, synchronous, active-high; clock clk):
  - All outputs 0.
  - FSM = UNLOCKED, good counter = 0, reference phase = 0.
  - Reset mid-operation overrides everything on that edge.
- Legality and decode:
  - MSB=0: code must be ones contiguous from LSB (0...01...1); phase = popcount.
  - MSB=1: code must be zeros contiguous from LSB (1...10...0); phase = N + number of zeros.
  - N=4 sequence: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7.
  - Any other code is illegal.
- Good transition: new phase == (reference + 1) mod 2N.
  - Wrap 7->0 is good.
  - Repeated phase (stall) is bad.
- Latency: every output reflects the in_valid sample exactly 1 cycle later, all outputs registered.
- in_valid=0:
  - No state change; phase holds.
  - phase_valid=0, err_pulse=0.
  - Gaps of any length do not count as errors.
- FSM, evaluated only when in_valid=1:
  - UNLOCKED:
    - Legal code -> ACQUIRE; reference = phase; good = 0.
    - Illegal code -> stay; error.
  - ACQUIRE:
    - Illegal code -> UNLOCKED; error.
    - Bad transition -> stay; reference = phase; good = 0; no error.
    - Good transition -> good+1, reference = phase; when good reaches LOCK_CNT -> LOCKED.
  - LOCKED:
    - Good transition -> stay; reference = phase.
    - Bad transition -> ACQUIRE; reference = phase; good = 0; error.
    - Illegal code -> UNLOCKED; error.
- Outputs per sample:
  - phase_valid=1 only for legal samples; illegal samples leave phase unchanged.
  - locked = registered (state==LOCKED) after the update.
- err_count:
  - +1 per error, saturating at 2^ERR_W-1.
  - clr_err has priority: clr_err with a coincident error gives err_count = 0, but err_pulse still asserts.

Optional Feature:
- Macro: JSM_STICKY_ERR_EN.
- Defined:
  - Adds output err_sticky (1 bit, reset 0).
  - Sets on the same edge as any err_pulse.
  - Clears only on clr_err or reset; clr_err wins over a coincident error.
- Undefined: port and logic absent; other behaviour identical.

Test Plan:
- Lock acquisition (N=4, LOCK_CNT=4): reset, then in_valid=1 with 0000,0001,0011,0111,1111,1110 -> phase 0,1,2,3,4,5 each 1 cycle after its sample; phase_valid=1 each; locked rises with output of 5th sample (phase 4); err_count=0.
- Illegal code while locked: drive 0101 -> err_pulse=1 for 1 cycle, err_count=1, locked=0, phase_valid=0, phase holds previous value; FSM UNLOCKED; next legal code enters ACQUIRE.
- Skipped step: locked at phase 3, drive 1110 -> err_pulse=1, locked=0, phase=5; then 1100,1000,0000,0001 -> locked=1 again; wrap 1000->0000 counts as good.
- Gaps and stall: locked, in_valid=0 for 3 cycles then next code -> no err_pulse, locked stays 1; repeat the same code twice -> err_pulse=1, locked=0.
- Saturation and clear (ERR_W=2): 5 illegal samples -> err_count=1,2,3,3,3; clr_err with an illegal sample -> err_count=0, err_pulse=1; with JSM_STICKY_ERR_EN, err_sticky=0 after the clear edge.
- Reset mid-ACQUIRE: after 2 good transitions assert reset 1 cycle -> all outputs 0 next cycle; next legal sample behaves as first-after-reset (needs 1+LOCK_CNT samples to lock).
